call_ret_unit: RTL and testbench

CALL_RET_UNIT -- requirements
Module: call_ret_unit

---
 rtl/call_ret_unit_if.sv | 31 +++
 rtl/call_ret_unit.sv | 102 ++++++++++
 tb/tb_call_ret_unit.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/call_ret_unit_if.sv
// Bus between the call/return unit, its instruction sequencer and the external
// return-address stack. The unit sits on the slave modport.
interface call_ret_unit_if;
   logic       call_req;
   logic       ret_req;
   logic [7:0] target;
   logic [7:0] pc_in;
   logic       err_clr;
   logic [7:0] stk_data;
   logic       stk_push;
   logic       stk_pop;
   logic [7:0] stk_value;
   logic [7:0] pc_out;
   logic       pc_load;
   logic       ack;
   logic [8:0] depth;
   logic       ovf_err;
   logic       unf_err;

   modport master (
      output call_req, ret_req, target, pc_in, err_clr, stk_data,
      input  stk_push, stk_pop, stk_value, pc_out, pc_load, ack, depth,
             ovf_err, unf_err
   );

   modport slave (
      input  call_req, ret_req, target, pc_in, err_clr, stk_data,
      output stk_push, stk_pop, stk_value, pc_out, pc_load, ack, depth,
             ovf_err, unf_err
   );
endinterface

// File: rtl/call_ret_unit.sv
// CALL/RET sequencer: pushes return addresses to an external 256-entry stack,
// pops them back on RET, and strobes the new PC with sticky over/underflow flags.
module call_ret_unit #(
   parameter int UUID = 0,
   parameter     NAME = ""
) (
   input  logic            clk,
   input  logic            rst,
   call_ret_unit_if.slave  bus
);

   typedef enum logic [2:0] {IDLE, PUSH, POP, LOAD, ERR} state_t;

   localparam logic [8:0] FULL = 9'd256;

   state_t     state, state_nxt;
   logic       err_ack;
   logic [7:0] ret_addr;
   logic [7:0] tgt;
   logic [7:0] pc_sel;
   logic [8:0] depth_q;
   logic       ovf_q, unf_q;
   logic       start_call, set_ovf, set_unf;

   logic unused_params;
   assign unused_params = ^{UUID, NAME};

   // Requests are only looked at in IDLE; CALL wins over a simultaneous RET.
   assign start_call = (state == IDLE) && bus.call_req && (depth_q != FULL);
   assign set_ovf    = (state == IDLE) && bus.call_req && (depth_q == FULL);
   assign set_unf    = (state == IDLE) && !bus.call_req && bus.ret_req
                       && (depth_q == 9'd0);

   // NOTE: every combinational output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (bus.call_req)
               state_nxt = (depth_q == FULL) ? ERR : PUSH;
            else if (bus.ret_req)
               state_nxt = (depth_q == 9'd0) ? ERR : POP;
         end
         PUSH:    state_nxt = LOAD;
         POP:     state_nxt = LOAD;
         LOAD:    state_nxt = IDLE;
         ERR:     state_nxt = err_ack ? IDLE : ERR;
         default: state_nxt = IDLE;
      endcase
   end

   // ERR spans two cycles with ack in the second, so errored requests complete
   // with the same two-cycle latency as real CALL/RET operations.
   // NOTE: all state below uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         err_ack  <= 1'b0;
         ret_addr <= 8'h00;
         tgt      <= 8'h00;
         pc_sel   <= 8'h00;
         depth_q  <= 9'd0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         state   <= state_nxt;
         err_ack <= (state == ERR) && !err_ack;

         if (start_call) begin
            ret_addr <= bus.pc_in + 8'd1;
            tgt      <= bus.target;
         end

         if (state == PUSH) begin
            pc_sel <= tgt;
            if (depth_q != FULL) depth_q <= depth_q + 9'd1;
         end else if (state == POP) begin
            pc_sel <= bus.stk_data;
            if (depth_q != 9'd0) depth_q <= depth_q - 9'd1;
         end

         // A set on the same edge as err_clr takes precedence.
         ovf_q <= set_ovf | (ovf_q & ~bus.err_clr);
         unf_q <= set_unf | (unf_q & ~bus.err_clr);
      end
   end

   // pc_sel only changes on the edge into LOAD, so it already holds the last
   // loaded PC everywhere else.
   assign bus.stk_push  = (state == PUSH);
   assign bus.stk_pop   = (state == POP);
   assign bus.stk_value = (state == PUSH) ? ret_addr : 8'h00;
   assign bus.pc_out    = pc_sel;
   assign bus.pc_load   = (state == LOAD);
   assign bus.ack       = (state == LOAD) || ((state == ERR) && err_ack);
   assign bus.depth     = depth_q;
   assign bus.ovf_err   = ovf_q;
   assign bus.unf_err   = unf_q;

endmodule

// File: tb/tb_call_ret_unit.sv
// Scoreboard bench for call_ret_unit: stimulus queues expected pushes and acks,
// a negedge monitor compares them as the DUT presents strobes.
module tb_call_ret_unit;

   typedef struct {
      int         cyc;
      bit         load;
      logic [7:0] pc;
      int         depth;
      bit         ovf;
      bit         unf;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   call_ret_unit_if bus();

   call_ret_unit #(.UUID(7), .NAME("cru0")) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // External return-address stack, reset together with the DUT.
   logic [7:0] mem [256];
   logic [8:0] sp;
   always @(posedge clk or negedge rst) begin
      if (!rst) sp <= 9'd0;
      else if (bus.stk_push && sp != 9'd256) begin
         mem[sp[7:0]] <= bus.stk_value;
         sp <= sp + 9'd1;
      end else if (bus.stk_pop && sp != 9'd0) sp <= sp - 9'd1;
   end
   assign bus.stk_data = (bus.stk_pop && sp != 9'd0) ? mem[sp[7:0] - 8'd1] : 8'h00;

   // Reference model state.
   exp_t       ack_q[$];
   logic [7:0] push_q[$];
   logic [7:0] m_stk[$];
   int         m_depth = 0;
   int         m_pops = 0;
   logic [7:0] m_pc = 8'h00;
   bit         m_ovf = 1'b0;
   bit         m_unf = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: consumes expectations whenever the DUT strobes.
   always @(negedge clk) begin
      if (rst) begin
         if (bus.stk_push || bus.stk_pop)
            check("push_pop_exclusive", {31'd0, bus.stk_push & bus.stk_pop}, 32'd0);
         if (bus.stk_push) begin
            if (push_q.size() == 0) check("unexpected_push", 32'd1, 32'd0);
            else check("stk_value", {24'd0, bus.stk_value}, {24'd0, push_q.pop_front()});
         end
         if (bus.stk_pop) begin
            check("unexpected_pop", {31'd0, m_pops == 0}, 32'd0);
            if (m_pops > 0) m_pops--;
         end
         if (bus.ack) begin
            if (ack_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
            else begin
               exp_t e;
               e = ack_q.pop_front();
               check("ack_latency", cyc, e.cyc);
               check("pc_load", {31'd0, bus.pc_load}, {31'd0, e.load});
               check("pc_out", {24'd0, bus.pc_out}, {24'd0, e.pc});
               check("depth", {23'd0, bus.depth}, e.depth);
               check("ovf_err", {31'd0, bus.ovf_err}, {31'd0, e.ovf});
               check("unf_err", {31'd0, bus.unf_err}, {31'd0, e.unf});
            end
         end
      end
   end

   task automatic wait_ack();
      bit seen = 1'b0;
      for (int i = 0; i < 8 && !seen; i++) begin
         @(negedge clk);
         if (bus.ack) seen = 1'b1;
      end
      if (!seen) begin
         check("ack_timeout", 32'd0, 32'd1);
         ack_q.delete();
         push_q.delete();
      end
   endtask

   // Queue the model's predictions for a one-cycle request pulse, then issue it.
   task automatic predict(input bit c, input bit r, input logic [7:0] pc,
                          input logic [7:0] tg, input bit clr, input int at_cyc);
      exp_t       e;
      logic [7:0] ra;
      e.cyc = at_cyc;
      e.load = 1'b0;
      if (clr) begin m_ovf = 1'b0; m_unf = 1'b0; end
      if (c) begin
         if (m_depth == 256) m_ovf = 1'b1;
         else begin
            ra = pc + 8'd1;
            push_q.push_back(ra);
            m_stk.push_back(ra);
            m_depth++;
            m_pc = tg;
            e.load = 1'b1;
         end
      end else if (r) begin
         if (m_depth == 0) m_unf = 1'b1;
         else begin
            m_pc = m_stk.pop_back();
            m_depth--;
            m_pops++;
            e.load = 1'b1;
         end
      end
      e.pc = m_pc;
      e.depth = m_depth;
      e.ovf = m_ovf;
      e.unf = m_unf;
      ack_q.push_back(e);
   endtask

   task automatic op(input bit c, input bit r, input logic [7:0] pc,
                     input logic [7:0] tg, input bit clr);
      @(posedge clk); #1;
      predict(c, r, pc, tg, clr, cyc + 2);
      bus.call_req = c;
      bus.ret_req  = r;
      bus.pc_in    = pc;
      bus.target   = tg;
      bus.err_clr  = clr;
      @(posedge clk); #1;
      bus.call_req = 1'b0;
      bus.ret_req  = 1'b0;
      bus.err_clr  = 1'b0;
      wait_ack();
   endtask

   task automatic clear_flags();
      @(posedge clk); #1;
      bus.err_clr = 1'b1;
      m_ovf = 1'b0;
      m_unf = 1'b0;
      @(posedge clk); #1;
      bus.err_clr = 1'b0;
      check("ovf_after_clr", {31'd0, bus.ovf_err}, 32'd0);
      check("unf_after_clr", {31'd0, bus.unf_err}, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int k;
      rst = 1'b0;
      bus.call_req = 1'b0;
      bus.ret_req  = 1'b0;
      bus.err_clr  = 1'b0;
      bus.pc_in    = 8'h00;
      bus.target   = 8'h00;
      #3;
      check("rst_depth", {23'd0, bus.depth}, 32'd0);
      check("rst_pc_out", {24'd0, bus.pc_out}, 32'd0);
      check("rst_strobes", {28'd0, bus.stk_push, bus.stk_pop, bus.pc_load, bus.ack}, 32'd0);
      check("rst_flags", {30'd0, bus.ovf_err, bus.unf_err}, 32'd0);
      @(negedge clk) rst = 1'b1;

      // Basic CALL/RET, then underflow and clear.
      op(1'b1, 1'b0, 8'h10, 8'h40, 1'b0);
      op(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
      op(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
      clear_flags();

      // Depth 3, simultaneous requests, pc_in wrap.
      op(1'b1, 1'b0, 8'h01, 8'h80, 1'b0);
      op(1'b1, 1'b0, 8'h02, 8'h81, 1'b0);
      op(1'b1, 1'b0, 8'h03, 8'h82, 1'b0);
      op(1'b1, 1'b1, 8'h04, 8'h83, 1'b0);
      op(1'b1, 1'b0, 8'hFF, 8'h90, 1'b0);

      // call_req held high: second CALL sampled the cycle after the first ack.
      @(posedge clk); #1;
      k = cyc;
      predict(1'b1, 1'b0, 8'h20, 8'h30, 1'b0, k + 2);
      predict(1'b1, 1'b0, 8'h20, 8'h30, 1'b0, k + 5);
      bus.call_req = 1'b1;
      bus.pc_in    = 8'h20;
      bus.target   = 8'h30;
      repeat (5) @(posedge clk);
      #1;
      bus.call_req = 1'b0;
      wait_ack();

      for (int i = 0; i < 7; i++) op(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
      // Underflow on the same edge as err_clr: the set wins.
      op(1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
      clear_flags();

      // Fill to 256, overflow, then drain in LIFO order.
      for (int i = 0; i < 256; i++) op(1'b1, 1'b0, 8'(i), 8'(i) ^ 8'hA5, 1'b0);
      op(1'b1, 1'b0, 8'h77, 8'h66, 1'b0);
      for (int i = 0; i < 256; i++) op(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
      clear_flags();

      // Reset asserted during PUSH.
      @(posedge clk); #1;
      bus.call_req = 1'b1;
      bus.pc_in    = 8'h50;
      bus.target   = 8'h60;
      @(posedge clk); #2;
      check("push_before_rst", {31'd0, bus.stk_push}, 32'd1);
      rst = 1'b0;
      #1;
      bus.call_req = 1'b0;
      check("push_dropped", {31'd0, bus.stk_push}, 32'd0);
      check("rst_mid_depth", {23'd0, bus.depth}, 32'd0);
      check("rst_mid_ack", {31'd0, bus.ack}, 32'd0);
      check("rst_mid_pc", {24'd0, bus.pc_out}, 32'd0);
      m_stk.delete();
      m_depth = 0;
      m_pops  = 0;
      m_pc    = 8'h00;
      m_ovf   = 1'b0;
      m_unf   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b1;
      op(1'b1, 1'b0, 8'h50, 8'h60, 1'b0);

      repeat (4) @(posedge clk);
      check("acks_outstanding", ack_q.size(), 32'd0);
      check("pushes_outstanding", push_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
